// File: rtl/filt_pkg.sv
// Shared definitions for the moving-sum filter: delay-line modes and accumulator sizing.
package filt_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT = 2'b00,
        MODE_SWAP  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // The sum has TAPS+2 terms (new sample, stored taps, feedback), so this width never overflows.
    function automatic int acc_width(input int data_w, input int taps);
        return data_w + $clog2(taps + 2);
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift (floor) followed by signed saturation to OUT_W bits.
module sat_shift #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  acc,
    output logic [OUT_W-1:0] result,
    output logic             sat
);

    logic signed [IN_W-1:0]  shifted;
    logic [IN_W-OUT_W:0]     upper;

    assign shifted = $signed(acc) >>> SHIFT;
    assign upper   = shifted[IN_W-1:OUT_W-1];

    // The value fits only when every bit above the output sign bit copies that sign bit.
    always_comb begin
        sat    = !((&upper) || !(|upper));
        result = shifted[OUT_W-1:0];
        if (sat) begin
            result = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/avg_filter_pipe.sv
// Two-stage moving-sum filter: stage 1 sums the new sample, the delay line and the fed-back
// output; stage 2 shifts and saturates into o_y0. The delay line updates per sample by mode.
module avg_filter_pipe
    import filt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAPS   = 3,
    parameter int SHIFT  = 2,
    parameter int FB_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_x0,
    input  logic [1:0]        i_sel,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_y0,
    output logic              o_sat
);

    localparam int ACC_W = acc_width(DATA_W, TAPS);

    logic [DATA_W-1:0]       line_q [1:TAPS];
    logic [DATA_W-1:0]       line_d [1:TAPS];
    logic [DATA_W-1:0]       y_fb;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] s1_sum;
    logic                    s1_valid;
    logic [DATA_W-1:0]       sat_val;
    logic                    sat_flag;
    mode_e                   mode;

    assign mode = mode_e'(i_sel);
    assign y_fb = (FB_EN != 0) ? o_y0 : '0;

    // NOTE: blocking '=' is right for accumulating inside always_comb; registers below use '<=' only.
    always_comb begin
        sum = ACC_W'($signed(i_x0)) + ACC_W'($signed(y_fb));
        for (int k = 1; k <= TAPS; k++) begin
            sum += ACC_W'($signed(line_q[k]));
        end
    end

    // NOTE: copying the current contents first gives every path a value, so no latch is inferred.
    always_comb begin
        line_d = line_q;
        if (i_valid) begin
            case (mode)
                MODE_SHIFT: begin
                    line_d[1] = i_x0;
                    for (int k = 2; k <= TAPS; k++) line_d[k] = line_q[k-1];
                end
                MODE_SWAP: begin
                    line_d[1] = line_q[2];
                    line_d[2] = i_x0;
                    line_d[3] = line_q[1];
                    for (int k = 4; k <= TAPS; k++) line_d[k] = line_q[k-1];
                end
                MODE_CLEAR: begin
                    for (int k = 1; k <= TAPS; k++) line_d[k] = '0;
                end
                default: ;
            endcase
        end
    end

    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .acc    (s1_sum),
        .result (sat_val),
        .sat    (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line is a small flop bank, not a RAM, so clearing it on reset is intended.
            for (int k = 1; k <= TAPS; k++) line_q[k] <= '0;
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_y0     <= '0;
            o_sat    <= 1'b0;
        end else begin
            line_q   <= line_d;
            s1_valid <= i_valid;
            if (i_valid) s1_sum <= sum;
            o_valid  <= s1_valid;
            if (s1_valid) begin
                o_y0  <= sat_val;
                o_sat <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_avg_filter_pipe.sv
// Drives three filter configurations with one directed stimulus stream and checks each
// against an array-based model every cycle, plus literal expectations for the named scenarios.
module tb_avg_filter_pipe;
    import filt_pkg::*;

    localparam int NCFG = 3;
    localparam int CFG_DW [NCFG] = '{32, 8, 32};
    localparam int CFG_TP [NCFG] = '{3, 5, 3};
    localparam int CFG_SH [NCFG] = '{2, 0, 2};
    localparam int CFG_FB [NCFG] = '{1, 0, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_x0;
    logic [1:0]  i_sel;

    logic        va, vb, vc, sa, sb, sc;
    logic [31:0] ya, yc;
    logic [7:0]  yb;

    logic        dv [NCFG];
    logic [31:0] dy [NCFG];
    logic        ds [NCFG];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avg_filter_pipe #(.DATA_W(32), .TAPS(3), .SHIFT(2), .FB_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_x0(i_x0), .i_sel(i_sel),
        .o_valid(va), .o_y0(ya), .o_sat(sa));

    avg_filter_pipe #(.DATA_W(8), .TAPS(5), .SHIFT(0), .FB_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_x0(i_x0[7:0]), .i_sel(i_sel),
        .o_valid(vb), .o_y0(yb), .o_sat(sb));

    avg_filter_pipe #(.DATA_W(32), .TAPS(3), .SHIFT(2), .FB_EN(0)) u_dut_c (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_x0(i_x0), .i_sel(i_sel),
        .o_valid(vc), .o_y0(yc), .o_sat(sc));

    assign dv[0] = va;  assign dy[0] = ya;               assign ds[0] = sa;
    assign dv[1] = vb;  assign dy[1] = 32'($signed(yb)); assign ds[1] = sb;
    assign dv[2] = vc;  assign dy[2] = yc;               assign ds[2] = sc;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     due;
        int     c;
        longint y;
        logic   s;
    } res_t;

    longint xm [NCFG][17];
    longint ym [NCFG];
    logic   sm [NCFG];
    logic   vm [NCFG];
    res_t   pq [$];
    int     edge_n = 0;
    bit     live   = 1'b0;

    function automatic longint sext(input logic [31:0] v, input int dw);
        longint m = longint'(1) <<< (dw - 1);
        longint t = longint'(v) & ((m <<< 1) - 1);
        return (t ^ m) - m;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            live = 1'b1;
            pq.delete();
            for (int c = 0; c < NCFG; c++) begin
                for (int k = 0; k < 17; k++) xm[c][k] = 0;
                ym[c] = 0;
                sm[c] = 1'b0;
                vm[c] = 1'b0;
            end
        end else begin
            if (i_valid) begin
                for (int c = 0; c < NCFG; c++) begin
                    longint x0, s, r, hi, lo, o1, o2;
                    res_t   p;
                    x0 = sext(i_x0, CFG_DW[c]);
                    hi = (longint'(1) <<< (CFG_DW[c] - 1)) - 1;
                    lo = -hi - 1;
                    s  = x0 + ((CFG_FB[c] != 0) ? ym[c] : 0);
                    for (int k = 1; k <= CFG_TP[c]; k++) s += xm[c][k];
                    r  = s >>> CFG_SH[c];
                    p.due = edge_n + 1;
                    p.c   = c;
                    p.s   = (r > hi) || (r < lo);
                    p.y   = (r > hi) ? hi : (r < lo) ? lo : r;
                    pq.push_back(p);
                    case (mode_e'(i_sel))
                        MODE_SHIFT: begin
                            for (int k = CFG_TP[c]; k >= 2; k--) xm[c][k] = xm[c][k-1];
                            xm[c][1] = x0;
                        end
                        MODE_SWAP: begin
                            o1 = xm[c][1];
                            o2 = xm[c][2];
                            for (int k = CFG_TP[c]; k >= 4; k--) xm[c][k] = xm[c][k-1];
                            xm[c][3] = o1;
                            xm[c][2] = x0;
                            xm[c][1] = o2;
                        end
                        MODE_CLEAR: for (int k = 1; k <= CFG_TP[c]; k++) xm[c][k] = 0;
                        default: ;
                    endcase
                end
            end
            for (int c = 0; c < NCFG; c++) vm[c] = 1'b0;
            while (pq.size() > 0 && pq[0].due == edge_n) begin
                res_t p;
                p = pq.pop_front();
                ym[p.c] = p.y;
                sm[p.c] = p.s;
                vm[p.c] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int c = 0; c < NCFG; c++) begin
                check($sformatf("model cfg%0d o_valid", c), longint'(dv[c]), longint'(vm[c]));
                check($sformatf("model cfg%0d o_y0", c), longint'($signed(dy[c])), ym[c]);
                check($sformatf("model cfg%0d o_sat", c), longint'(ds[c]), longint'(sm[c]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic v, input logic [31:0] x, input mode_e sel);
        i_valid = v;
        i_x0    = x;
        i_sel   = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, MODE_SHIFT);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 32'd99, MODE_SHIFT);
        step(1'b1, 32'd99, MODE_SHIFT);
        rst = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic lit(input string name, input int c, input logic ev, input longint ey, input logic es);
        check({name, " o_valid"}, longint'(dv[c]), longint'(ev));
        check({name, " o_y0"}, longint'($signed(dy[c])), ey);
        check({name, " o_sat"}, longint'(ds[c]), longint'(es));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] x;
        mode_e       sel;
    } vec_t;

    vec_t tbl [18];

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_x0 = '0; i_sel = '0;

        // single positive sample
        do_reset();
        lit("reset state", 0, 1'b0, 0, 1'b0);
        step(1'b1, 32'd4, MODE_SHIFT);
        lit("single t+1", 0, 1'b0, 0, 1'b0);
        idle();
        lit("single t+2", 0, 1'b1, 1, 1'b0);
        idle();
        lit("single t+3", 0, 1'b0, 1, 1'b0);

        // back-to-back with feedback
        do_reset();
        step(1'b1, 32'd8, MODE_SHIFT);
        step(1'b1, 32'd8, MODE_SHIFT);
        lit("b2b out1", 0, 1'b1, 2, 1'b0);
        step(1'b1, 32'd8, MODE_SHIFT);
        lit("b2b out2", 0, 1'b1, 4, 1'b0);
        step(1'b1, 32'd8, MODE_SHIFT);
        lit("b2b out3", 0, 1'b1, 6, 1'b0);
        idle();
        lit("b2b out4", 0, 1'b1, 9, 1'b0);
        idle();
        lit("b2b hold", 0, 1'b0, 9, 1'b0);

        // negative floor
        do_reset();
        step(1'b1, 32'hFFFF_FFFB, MODE_SHIFT);
        idle();
        lit("neg floor", 0, 1'b1, -2, 1'b0);

        // saturation (8-bit, no shift, no feedback)
        do_reset();
        step(1'b1, 32'd127, MODE_SHIFT);
        step(1'b1, 32'd127, MODE_SHIFT);
        lit("sat out1", 1, 1'b1, 127, 1'b0);
        step(1'b1, 32'd127, MODE_SHIFT);
        lit("sat out2", 1, 1'b1, 127, 1'b1);
        step(1'b1, 32'd127, MODE_SHIFT);
        lit("sat out3", 1, 1'b1, 127, 1'b1);
        idle();
        lit("sat out4", 1, 1'b1, 127, 1'b1);

        // delay-line modes (no feedback)
        do_reset();
        step(1'b1, 32'd10, MODE_SHIFT);
        step(1'b1, 32'd20, MODE_SHIFT);
        step(1'b1, 32'd30, MODE_SHIFT);
        step(1'b1, 32'd40, MODE_SWAP);
        step(1'b1, 32'd0,  MODE_HOLD);
        lit("swap out", 2, 1'b1, 25, 1'b0);
        step(1'b1, 32'd4,  MODE_CLEAR);
        lit("hold out", 2, 1'b1, 22, 1'b0);
        step(1'b1, 32'd8,  MODE_SHIFT);
        lit("clear out", 2, 1'b1, 23, 1'b0);
        idle();
        lit("shift after clear", 2, 1'b1, 2, 1'b0);

        // reset mid-operation
        step(1'b1, 32'd100, MODE_SHIFT);
        step(1'b1, 32'd100, MODE_SHIFT);
        step(1'b1, 32'd100, MODE_SHIFT);
        step(1'b1, 32'd100, MODE_SHIFT);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        lit("rst drop cfg0", 0, 1'b0, 0, 1'b0);
        lit("rst drop cfg2", 2, 1'b0, 0, 1'b0);
        step(1'b1, 32'd0, MODE_SHIFT);
        idle();
        lit("line cleared", 0, 1'b1, 0, 1'b0);

        // mixed vectors with gaps, extremes and every mode
        tbl = '{
            '{1'b1, 32'h7FFF_FFFF, MODE_SHIFT}, '{1'b1, 32'h7FFF_FFFF, MODE_SHIFT},
            '{1'b1, 32'h7FFF_FFFF, MODE_SHIFT}, '{1'b1, 32'h7FFF_FFFF, MODE_SWAP},
            '{1'b0, 32'h0000_0000, MODE_SHIFT}, '{1'b1, 32'h8000_0000, MODE_SHIFT},
            '{1'b1, 32'h8000_0000, MODE_SHIFT}, '{1'b1, 32'h8000_0000, MODE_SHIFT},
            '{1'b1, 32'h8000_0000, MODE_HOLD},  '{1'b1, 32'hFFFF_FFFF, MODE_HOLD},
            '{1'b0, 32'h0000_0000, MODE_CLEAR}, '{1'b1, 32'h0000_3039, MODE_SWAP},
            '{1'b1, 32'hFFFF_FCF7, MODE_CLEAR}, '{1'b1, 32'h0000_0003, MODE_SHIFT},
            '{1'b1, 32'hFFFF_FF83, MODE_SWAP},  '{1'b1, 32'h0000_0081, MODE_SWAP},
            '{1'b0, 32'h0000_0000, MODE_SHIFT}, '{1'b0, 32'h0000_0000, MODE_SHIFT}
        };
        for (int i = 0; i < 18; i++) step(tbl[i].v, tbl[i].x, tbl[i].sel);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_filter_pipe.md
# avg_filter_pipe

Parametrised, pipelined moving-sum filter with recursive output feedback and per-sample delay-line mode control. Computes `(x0 + x[1..TAPS] + y_fb) >>> SHIFT` in signed arithmetic with saturation and a valid strobe. It sits in the sample datapath between the input stage and downstream decimation or threshold logic, replacing the fixed 32-bit, 3-tap averaging block.

## Interface
Parameters:
- DATA_W, 32, sample and output width; signed two's complement.
- TAPS, 3, number of stored past samples; legal range 3..16.
- SHIFT, 2, arithmetic right shift applied to the sum; legal range 0..ACC_W-1.
- FB_EN, 1, 1 adds the feedback term to the sum, 0 omits it.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high; sampled on the clk rising edge.
- i_valid  in  1  a sample is accepted on every cycle where i_valid=1. There is no backpressure.
- i_x0  in  DATA_W  input sample, signed.
- i_sel  in  2  mode for the accepted sample: 00 SHIFT, 01 SWAP, 10 HOLD, 11 CLEAR.
- o_valid  out  1  one-cycle strobe; o_y0 and o_sat carry a new result.
- o_y0  out  DATA_W  filter output, signed; holds its value between strobes.
- o_sat  out  1  the result in o_y0 was clipped; same timing as o_y0.

## Operation
- Delay line registers x[1..TAPS], reset to 0. x[1] is the newest sample.
- Feedback term y_fb is the current o_y0 register value at the cycle of acceptance. It is 0 when FB_EN=0.
- The sum always uses the pre-update delay-line contents: S = i_x0 + Σx[k] + y_fb.
- S is computed at ACC_W = DATA_W + clog2(TAPS+2) bits with sign extension, so the sum cannot overflow.
- R = S >>> SHIFT, floor rounding toward −∞.
- R is saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. o_sat=1 when clipping occurred.
- Delay-line update on an accepted sample, by mode:
  - SHIFT: x[k] ← x[k−1] for k≥2; x[1] ← i_x0.
  - SWAP: x[1] ← x[2]; x[2] ← i_x0; x[3] ← x[1]; x[k] ← x[k−1] for k≥4.
  - HOLD: delay line unchanged. The sample is still summed and produces an output.
  - CLEAR: all x[k] ← 0. The output for this sample uses the pre-clear contents.
- i_valid=0: the delay line and o_y0 are unchanged, and no output is generated.
- Reset value of every register is 0: delay line, pipeline stages, o_y0, o_valid, o_sat.

## Timing
- Stage 1 registers S and a valid bit. Stage 2 registers the shift and saturate result into o_y0 and o_sat and sets o_valid.
- Latency: a sample accepted in cycle t produces o_valid=1 in cycle t+2.
- Throughput: one sample per cycle.
- Back-to-back samples: the sample accepted at t uses o_y0(t), which is the output of sample n−2, or an older output if gaps occurred.
- rst=1 in any cycle clears all state at that edge; in-flight samples are dropped with no o_valid.
- i_valid is ignored while rst=1.
- All four i_sel values are legal every cycle. Mode changes take effect per sample, with no settling cycles.

## Structure
- Package filt_pkg holds:
  - mode constants MODE_SHIFT, MODE_SWAP, MODE_HOLD and MODE_CLEAR;
  - a function returning ACC_W for DATA_W and TAPS.
- Sub-module sat_shift performs the combinational arithmetic shift plus saturation.
  - Parameters: IN_W, OUT_W and SHIFT.
  - Outputs: the value and the sat flag.
  - It is instantiated once, between stage 1 and stage 2.

## Test plan
Defaults unless stated otherwise: DATA_W=32, TAPS=3, SHIFT=2, FB_EN=1.
- **Single positive sample:** reset, then one sample i_x0=4, SHIFT mode at cycle t → o_valid only at t+2, o_y0=1, o_sat=0.
- **Back-to-back samples:** reset, then 8, 8, 8, 8 on consecutive cycles in SHIFT mode → outputs 2, 4, 6, 9 on cycles t+2..t+5.
- **Negative floor:** reset, then i_x0=−5 → o_y0=0xFFFFFFFE (−2).
- **Saturation:** DATA_W=8, SHIFT=0, FB_EN=0; four samples of 127 back-to-back → o_y0=127 each time, o_sat=0,1,1,1.
- **Modes:** FB_EN=0.
  - Shift in 10, 20, 30 → x=[30,20,10].
  - SWAP with 40 → x=[20,40,30].
  - HOLD with 0 → output 22 (90>>>2).
  - CLEAR with 4 → output 23.
  - SHIFT with 8 → output 2.
- **Reset mid-operation:** accept a sample at t, assert rst at t+1 → no o_valid at t+2, and o_y0, o_sat and the delay line are all 0.
